// File: rtl/vote_filter.sv
// vote_filter: registered threshold/parity voter followed by a symmetric
// persistence filter. The filtered output f changes only after HOLD
// consecutive sampled cycles agree on the new value; rise/fall pulse for one
// clock on the edge where f changes.
//
// Interface timing: there is no valid/ready handshake. en is a sample
// qualifier. On an edge with en=1, in_vec and mode are sampled and the filter
// advances. On an edge with en=0, every register holds its value, except
// rise/fall, which return to 0. All outputs are driven directly from
// registers, so there is no combinational path from any input to any output.
//
// The dbg_state_o and dbg_run_o outputs expose the filter FSM state and its
// run counter so that external checkers can observe them.

module vote_filter #(
  parameter int WIDTH  = 4,  // number of voted bits, >= 2
  parameter int THRESH = 3,  // ones-count needed for a true threshold vote, 1..WIDTH
  parameter int HOLD   = 2   // consecutive sampled cycles needed to change f, >= 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             in_vec,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         vote,
  output logic                         f,
  output logic                         rise,
  output logic                         fall,
  output logic [1:0]                   dbg_state_o,
  output logic [$clog2(HOLD+1)-1:0]    dbg_run_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HOLD + 1);

  localparam logic [CW-1:0] THRESH_C    = CW'(THRESH);
  localparam logic [RW-1:0] HOLD_C      = RW'(HOLD);
  localparam bit            HOLD_IS_ONE = (HOLD == 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,  // f=0, no qualifying run in progress
    S_ARMING    = 2'd1,  // f=0, counting consecutive vote=1 samples
    S_ACTIVE    = 2'd2,  // f=1, no release run in progress
    S_RELEASING = 2'd3   // f=1, counting consecutive vote=0 samples
  } state_e;

  // Ones-count of a vector, written as a simple adder chain.
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: popcount and raw decision
  // ---------------------------------------------------------------------
  logic [CW-1:0] pop_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vote_q, vote_d;

  // Next values of the count and raw vote; both hold while en=0.
  always_comb begin
    pop_w  = popcount(in_vec);
    cnt_d  = cnt_q;
    vote_d = vote_q;
    if (en) begin
      cnt_d  = pop_w;
      // Parity ignores THRESH; cnt is still the popcount in either mode.
      vote_d = mode ? (^in_vec) : (pop_w >= THRESH_C);
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      vote_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      vote_q <= vote_d;
    end
  end

  // ---------------------------------------------------------------------
  // Persistence filter FSM
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          f_q, f_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [RW-1:0] run_inc_w;
  logic          hold_hit_w;

  // run_q is strictly below HOLD inside ARMING and RELEASING, so the
  // increment cannot wrap before it is compared with HOLD.
  always_comb begin
    run_inc_w  = run_q + 1'b1;
    hold_hit_w = (run_inc_w == HOLD_C);
  end

  // Next state, run counter and f; rise/fall default to 0 so they last one clock.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    f_d     = f_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (vote_q) begin
            if (HOLD_IS_ONE) begin
              state_d = S_ACTIVE;
              run_d   = '0;
              f_d     = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = S_ARMING;
              run_d   = RW'(1);
            end
          end
        end
        S_ARMING: begin
          if (vote_q) begin
            if (hold_hit_w) begin
              state_d = S_ACTIVE;
              run_d   = '0;
              f_d     = 1'b1;
              rise_d  = 1'b1;
            end else begin
              run_d = run_inc_w;
            end
          end else begin
            // A disagreeing sample breaks the run.
            state_d = S_IDLE;
            run_d   = '0;
          end
        end
        S_ACTIVE: begin
          if (!vote_q) begin
            if (HOLD_IS_ONE) begin
              state_d = S_IDLE;
              run_d   = '0;
              f_d     = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = S_RELEASING;
              run_d   = RW'(1);
            end
          end
        end
        S_RELEASING: begin
          if (!vote_q) begin
            if (hold_hit_w) begin
              state_d = S_IDLE;
              run_d   = '0;
              f_d     = 1'b0;
              fall_d  = 1'b1;
            end else begin
              run_d = run_inc_w;
            end
          end else begin
            // A disagreeing sample cancels the release.
            state_d = S_ACTIVE;
            run_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          run_d   = '0;
          f_d     = 1'b0;
        end
      endcase
    end
  end

  // Filter registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      f_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      f_q     <= f_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs, all taken straight from registers
  // ---------------------------------------------------------------------
  assign cnt         = cnt_q;
  assign vote        = vote_q;
  assign f           = f_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign dbg_state_o = state_q;
  assign dbg_run_o   = run_q;

endmodule

// File: tb/tb_vote_filter.sv
// Bench for vote_filter with the default parameters (WIDTH=4, THRESH=3, HOLD=2).
// The driver applies directed vectors and pushes the hand-computed outputs
// expected after each edge. The monitor pops and compares those outputs on
// the falling edge, or immediately when sample_ev fires (async reset checks).

module tb_vote_filter;

  localparam int WIDTH = 4;
  localparam int CW    = 3;
  localparam int RW    = 2;
  localparam int EW    = CW + 4 + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] in_vec;
  logic [CW-1:0]    cnt;
  logic             vote;
  logic             f;
  logic             rise;
  logic             fall;
  logic [1:0]       dbg_state;
  logic [RW-1:0]    dbg_run;

  vote_filter #(.WIDTH(4), .THRESH(3), .HOLD(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .in_vec      (in_vec),
    .cnt         (cnt),
    .vote        (vote),
    .f           (f),
    .rise        (rise),
    .fall        (fall),
    .dbg_state_o (dbg_state),
    .dbg_run_o   (dbg_run)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  bit            drain_req    = 1'b0;
  event          sample_ev;

  function automatic logic [EW-1:0] pack(input logic [CW-1:0] c, input logic v,
                                         input logic ff, input logic r,
                                         input logic fl, input logic [1:0] s);
    return {c, v, ff, r, fl, s};
  endfunction

  // Monitor: compares DUT outputs with the oldest expected entry.
  always @(negedge clk or sample_ev) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    string         n;
    if (drain_req) begin
      tests_run++;
      if (exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      drain_req = 1'b0;
    end else if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {cnt, vote, f, rise, fall, dbg_state};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL %s: got cnt=%0d vote=%b f=%b rise=%b fall=%b st=%0d, expected cnt=%0d vote=%b f=%b rise=%b fall=%b st=%0d",
                 n, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
                 e[8:6], e[5], e[4], e[3], e[2], e[1:0]);
      end
      tests_run++;
      if (rise && fall) begin
        tests_failed++;
        $display("FAIL %s rise_fall_excl: got rise=1 fall=1, expected not both", n);
      end
    end
  end

  // Driver: apply one sample, push the outputs expected after the next edge.
  task automatic step(input logic e_i, input logic m_i, input logic [WIDTH-1:0] v_i,
                      input logic [CW-1:0] c, input logic v, input logic ff,
                      input logic r, input logic fl, input logic [1:0] s,
                      input string n);
    @(negedge clk);
    #1;
    en     = e_i;
    mode   = m_i;
    in_vec = v_i;
    exp_q.push_back(pack(c, v, ff, r, fl, s));
    name_q.push_back(n);
    @(posedge clk);
  endtask

  // Immediate check between edges (used for asynchronous reset).
  task automatic check_now(input string n);
    exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE));
    name_q.push_back(n);
    -> sample_ev;
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    in_vec = '0;
    #12;
    check_now("reset_initial");
    rst_n = 1'b1;

    // Threshold acquisition: 0111 held
    step(1, 0, 4'b0111, 3, 1, 0, 0, 0, ST_IDLE, "acq_e1");
    step(1, 0, 4'b0111, 3, 1, 0, 0, 0, ST_ARM,  "acq_e2");
    step(1, 0, 4'b0111, 3, 1, 1, 1, 0, ST_ACT,  "acq_e3_rise");
    step(1, 0, 4'b0111, 3, 1, 1, 0, 0, ST_ACT,  "acq_e4_hold");

    // Release with 0011 (cnt=2, just below THRESH)
    step(1, 0, 4'b0011, 2, 0, 1, 0, 0, ST_ACT,  "rel_e1");
    step(1, 0, 4'b0011, 2, 0, 1, 0, 0, ST_REL,  "rel_e2");
    step(1, 0, 4'b0011, 2, 0, 0, 0, 1, ST_IDLE, "rel_e3_fall");

    // Reacquire with 1111, then a release cancelled by one 1111 sample
    step(1, 0, 4'b1111, 4, 1, 0, 0, 0, ST_IDLE, "reacq_e1");
    step(1, 0, 4'b1111, 4, 1, 0, 0, 0, ST_ARM,  "reacq_e2");
    step(1, 0, 4'b1111, 4, 1, 1, 1, 0, ST_ACT,  "reacq_e3_rise");
    step(1, 0, 4'b0011, 2, 0, 1, 0, 0, ST_ACT,  "cancel_e1");
    step(1, 0, 4'b1111, 4, 1, 1, 0, 0, ST_REL,  "cancel_e2");
    step(1, 0, 4'b0011, 2, 0, 1, 0, 0, ST_ACT,  "cancel_e3_back");
    step(1, 0, 4'b0011, 2, 0, 1, 0, 0, ST_REL,  "cancel_e4");
    step(1, 0, 4'b0011, 2, 0, 0, 0, 1, ST_IDLE, "cancel_e5_fall");

    // Glitch rejection: single qualifying sample
    step(1, 0, 4'b1110, 3, 1, 0, 0, 0, ST_IDLE, "glitch_e1");
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, ST_ARM,  "glitch_e2");
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, ST_IDLE, "glitch_e3_idle");

    // Parity mode
    step(1, 1, 4'b0001, 1, 1, 0, 0, 0, ST_IDLE, "par_0001");
    step(1, 1, 4'b0011, 2, 0, 0, 0, 0, ST_ARM,  "par_0011");
    step(1, 1, 4'b1011, 3, 1, 0, 0, 0, ST_IDLE, "par_1011_e1");
    step(1, 1, 4'b1011, 3, 1, 0, 0, 0, ST_ARM,  "par_1011_e2");
    step(1, 1, 4'b1011, 3, 1, 1, 1, 0, ST_ACT,  "par_1011_rise");
    step(1, 1, 4'b1111, 4, 0, 1, 0, 0, ST_ACT,  "par_1111_e1");
    step(1, 1, 4'b1111, 4, 0, 1, 0, 0, ST_REL,  "par_1111_e2");
    step(1, 1, 4'b1111, 4, 0, 0, 0, 1, ST_IDLE, "par_1111_fall");

    // Enable hold inside ARMING
    step(1, 0, 4'b1111, 4, 1, 0, 0, 0, ST_IDLE, "en_e1");
    step(1, 0, 4'b1111, 4, 1, 0, 0, 0, ST_ARM,  "en_e2_arm");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b0000, 4, 1, 0, 0, 0, ST_ARM, "en_hold");
    end
    step(1, 0, 4'b1111, 4, 1, 1, 1, 0, ST_ACT,  "en_resume_rise");
    step(0, 0, 4'b0000, 4, 1, 1, 0, 0, ST_ACT,  "en_off_clears_rise");

    // Asynchronous reset between edges while f=1
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_async");
    rst_n = 1'b1;
    step(1, 0, 4'b0111, 3, 1, 0, 0, 0, ST_IDLE, "post_rst_e1");
    step(1, 0, 4'b0111, 3, 1, 0, 0, 0, ST_ARM,  "post_rst_e2");
    step(1, 0, 4'b0111, 3, 1, 1, 1, 0, ST_ACT,  "post_rst_e3_rise");

    // Let the monitor consume the last entry, then confirm nothing is pending
    @(negedge clk);
    #1;
    drain_req = 1'b1;
    -> sample_ev;
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
